// File: rtl/rab_arb_fsm.sv
// Round-robin arbiter that lets one slave port at a time use the shared RAB lookup,
// registers the lookup result as per-port pulses and waits for the port to forward it.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_READY | idle; grants the next requesting port in round-robin order
// S_WAIT  | result issued; waiting for sent[gnt_reg] or the WAIT timeout

module rab_arb_fsm #(
    parameter  int AXI_ADDR_WIDTH = 40,
    parameter  int NUM_PORTS      = 4,
    parameter  int TIMEOUT        = 255,
    localparam int IDX_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_W          = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic [NUM_PORTS-1:0]      addr_valid,
    input  logic [NUM_PORTS-1:0]      sent,
    input  logic                      no_hit,
    input  logic                      multiple_hit,
    input  logic                      no_prot,
    input  logic                      prefetch,
    input  logic                      cache_coherent,
    input  logic [AXI_ADDR_WIDTH-1:0] out_addr,
    output logic [IDX_W-1:0]          gnt_idx,
    output logic [NUM_PORTS-1:0]      accept,
    output logic [NUM_PORTS-1:0]      drop,
    output logic [NUM_PORTS-1:0]      miss,
    output logic [AXI_ADDR_WIDTH-1:0] out_addr_reg,
    output logic                      cache_coherent_reg,
    output logic                      int_miss,
    output logic                      int_multi,
    output logic                      int_prot,
    output logic                      int_prefetch,
    output logic                      int_timeout,
    output logic                      busy
);

    typedef enum logic {
        S_READY = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_reg;
    logic [IDX_W-1:0] rr_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             err;
    logic             any_req;

    // Scan from the highest offset down so the port closest to rr_ptr wins.
    always_comb begin
        int sum;
        gnt_idx = rr_ptr;
        sum     = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_PORTS) begin
                sum = sum - NUM_PORTS;
            end
            if (addr_valid[IDX_W'(sum)]) begin
                gnt_idx = IDX_W'(sum);
            end
        end
    end

    always_comb begin
        if (gnt_idx == IDX_W'(NUM_PORTS - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = gnt_idx + IDX_W'(1);
        end
    end

    assign err     = no_hit | multiple_hit | ~no_prot | prefetch;
    assign any_req = |addr_valid;
    assign busy    = (state == S_WAIT);

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state              <= S_READY;
            rr_ptr             <= '0;
            gnt_reg            <= '0;
            wait_cnt           <= '0;
            accept             <= '0;
            drop               <= '0;
            miss               <= '0;
            out_addr_reg       <= '0;
            cache_coherent_reg <= 1'b0;
            int_miss           <= 1'b0;
            int_multi          <= 1'b0;
            int_prot           <= 1'b0;
            int_prefetch       <= 1'b0;
            int_timeout        <= 1'b0;
        end else begin
            accept       <= '0;
            drop         <= '0;
            miss         <= '0;
            int_miss     <= 1'b0;
            int_multi    <= 1'b0;
            int_prot     <= 1'b0;
            int_prefetch <= 1'b0;
            int_timeout  <= 1'b0;

            case (state)
                S_READY: begin
                    if (any_req) begin
                        state              <= S_WAIT;
                        gnt_reg            <= gnt_idx;
                        rr_ptr             <= rr_next;
                        wait_cnt           <= '0;
                        accept[gnt_idx]    <= ~err;
                        drop[gnt_idx]      <= err;
                        miss[gnt_idx]      <= no_hit;
                        int_miss           <= no_hit;
                        int_multi          <= multiple_hit;
                        int_prot           <= ~no_prot;
                        int_prefetch       <= ~no_hit & prefetch;
                        out_addr_reg       <= out_addr;
                        cache_coherent_reg <= cache_coherent;
                    end
                end

                S_WAIT: begin
                    // A completing sent wins over the timeout in the same cycle.
                    if (sent[gnt_reg]) begin
                        state    <= S_READY;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= S_READY;
                        wait_cnt    <= '0;
                        int_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= S_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rab_arb_fsm.sv
// Bench for rab_arb_fsm: round-robin vector table with a result scoreboard,
// plus timeout, sent-at-timeout and reset-during-WAIT sequences.

module tb_rab_arb_fsm;

    localparam int AW = 40;
    localparam int NP = 4;
    localparam int TO = 8;

    logic          clk;
    logic          rst_b;
    logic [NP-1:0] addr_valid;
    logic [NP-1:0] sent;
    logic          no_hit, multiple_hit, no_prot, prefetch, cache_coherent;
    logic [AW-1:0] out_addr;
    logic [1:0]    gnt_idx;
    logic [NP-1:0] accept, drop, miss;
    logic [AW-1:0] out_addr_reg;
    logic          cache_coherent_reg;
    logic          int_miss, int_multi, int_prot, int_prefetch, int_timeout;
    logic          busy;

    rab_arb_fsm #(
        .AXI_ADDR_WIDTH(AW),
        .NUM_PORTS     (NP),
        .TIMEOUT       (TO)
    ) dut (
        .Clk_CI            (clk),
        .Rst_RBI           (rst_b),
        .addr_valid        (addr_valid),
        .sent              (sent),
        .no_hit            (no_hit),
        .multiple_hit      (multiple_hit),
        .no_prot           (no_prot),
        .prefetch          (prefetch),
        .cache_coherent    (cache_coherent),
        .out_addr          (out_addr),
        .gnt_idx           (gnt_idx),
        .accept            (accept),
        .drop              (drop),
        .miss              (miss),
        .out_addr_reg      (out_addr_reg),
        .cache_coherent_reg(cache_coherent_reg),
        .int_miss          (int_miss),
        .int_multi         (int_multi),
        .int_prot          (int_prot),
        .int_prefetch      (int_prefetch),
        .int_timeout       (int_timeout),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  av;
        logic        nh, mh, np, pf, cc;
        logic [39:0] addr;
        logic [1:0]  gnt;
        logic [3:0]  acc, drp, mis;
        logic [3:0]  ints;   // {miss, multi, prot, prefetch}
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] av, input logic nh, input logic mh,
                                input logic np, input logic pf, input logic cc,
                                input logic [39:0] addr, input logic [1:0] gnt,
                                input logic [3:0] acc, input logic [3:0] drp,
                                input logic [3:0] mis, input logic [3:0] ints);
        vec_t v;
        v.av = av; v.nh = nh; v.mh = mh; v.np = np; v.pf = pf; v.cc = cc;
        v.addr = addr; v.gnt = gnt; v.acc = acc; v.drp = drp; v.mis = mis; v.ints = ints;
        return v;
    endfunction

    task automatic drive_lookup(input logic [3:0] av, input logic nh, input logic mh,
                                input logic np, input logic pf, input logic cc,
                                input logic [39:0] addr);
        addr_valid = av; no_hit = nh; multiple_hit = mh; no_prot = np;
        prefetch = pf; cache_coherent = cc; out_addr = addr;
    endtask

    // Called just after a negedge while the DUT is READY; returns just after a negedge.
    task automatic run_vec(input int n, input vec_t v);
        vec_t e;
        drive_lookup(v.av, v.nh, v.mh, v.np, v.pf, v.cc, v.addr);
        sent = '0;
        #1;
        chk($sformatf("v%0d_gnt_idx", n), 64'(gnt_idx), 64'(v.gnt));
        chk($sformatf("v%0d_busy_pre", n), 64'(busy), 64'd0);
        sb.push_back(v);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL v%0d_scoreboard_empty actual=0 expected=1", n);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_accept", n), 64'(accept), 64'(e.acc));
            chk($sformatf("v%0d_drop", n), 64'(drop), 64'(e.drp));
            chk($sformatf("v%0d_miss", n), 64'(miss), 64'(e.mis));
            chk($sformatf("v%0d_ints", n),
                64'({int_miss, int_multi, int_prot, int_prefetch}), 64'(e.ints));
            chk($sformatf("v%0d_out_addr_reg", n), 64'(out_addr_reg), 64'(e.addr));
            chk($sformatf("v%0d_cc_reg", n), 64'(cache_coherent_reg), 64'(e.cc));
            chk($sformatf("v%0d_busy", n), 64'(busy), 64'd1);
        end
        sent = 4'(1 << v.gnt);
        @(negedge clk);
        chk($sformatf("v%0d_released", n), 64'(busy), 64'd0);
        chk($sformatf("v%0d_pulse_end", n),
            64'({accept, drop, miss, int_miss, int_multi, int_prot, int_prefetch, int_timeout}), 64'd0);
        sent       = '0;
        addr_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int to_seen;

        //                av      nh   mh   np   pf   cc   addr            gnt   acc      drp      mis      ints
        vecs[0]  = mk(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h00_1000_0000, 2'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        vecs[1]  = mk(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 40'h00_1000_1000, 2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        vecs[2]  = mk(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h12_3456_7890, 2'd2, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        vecs[3]  = mk(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 40'hFF_FFFF_F000, 2'd3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        vecs[4]  = mk(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h00_0000_0040, 2'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        vecs[5]  = mk(4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 40'h0A_0000_0000, 2'd1, 4'b0000, 4'b0010, 4'b0010, 4'b1000);
        vecs[6]  = mk(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 40'h0B_0000_0100, 2'd2, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        vecs[7]  = mk(4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0C_0000_0200, 2'd3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        vecs[8]  = mk(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0D_0000_0300, 2'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0110);
        vecs[9]  = mk(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 40'h0E_0000_0400, 2'd0, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        vecs[10] = mk(4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 40'h0F_0000_0500, 2'd3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        vecs[11] = mk(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40'h10_0000_0600, 2'd2, 4'b0000, 4'b0100, 4'b0000, 4'b0010);

        rst_b = 1'b0;
        sent  = '0;
        drive_lookup(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0);
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_pulses",
            64'({accept, drop, miss, int_miss, int_multi, int_prot, int_prefetch, int_timeout}), 64'd0);
        chk("reset_out_addr_reg", 64'(out_addr_reg), 64'd0);
        chk("reset_gnt_idx", 64'(gnt_idx), 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: rr_ptr is 3, only port 0 requests; foreign sent pulses are ignored.
        drive_lookup(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h20_0000_0000);
        #1;
        chk("to_gnt_idx", 64'(gnt_idx), 64'd0);
        @(negedge clk);
        chk("to_accept", 64'(accept), 64'b0001);
        sent    = 4'b1110;
        n       = 1;
        to_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (int_timeout) to_seen++;
        end
        chk("to_wait_len", 64'(n), 64'(TO));
        chk("to_early_pulse", 64'(to_seen), 64'd0);
        chk("to_pulse", 64'(int_timeout), 64'd1);
        addr_valid = '0;
        sent       = '0;
        @(negedge clk);
        chk("to_pulse_end", 64'(int_timeout), 64'd0);
        chk("to_idle", 64'(busy), 64'd0);

        // sent[gnt_reg] in the same cycle the counter reaches TIMEOUT.
        drive_lookup(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 40'h21_0000_0000);
        #1;
        chk("edge_gnt_idx", 64'(gnt_idx), 64'd1);
        @(negedge clk);
        chk("edge_accept", 64'(accept), 64'b0010);
        n = 1;
        for (int i = 2; i <= TO; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (i == TO) sent = 4'b0010;
        end
        chk("edge_busy_len", 64'(n), 64'(TO));
        @(negedge clk);
        chk("edge_ready", 64'(busy), 64'd0);
        chk("edge_no_timeout", 64'(int_timeout), 64'd0);
        sent       = '0;
        addr_valid = '0;

        // Reset in the middle of WAIT with every port requesting.
        drive_lookup(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 40'h22_0000_0000);
        #1;
        chk("rst_gnt_idx", 64'(gnt_idx), 64'd2);
        @(negedge clk);
        chk("rst_accept", 64'(accept), 64'b0100);
        chk("rst_busy", 64'(busy), 64'd1);
        #1 rst_b = 1'b0;
        #1;
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_out_addr", 64'(out_addr_reg), 64'd0);
        chk("rst_async_cc", 64'(cache_coherent_reg), 64'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("rst_release_gnt_idx", 64'(gnt_idx), 64'd0);
        chk("rst_release_pulses",
            64'({accept, drop, miss, int_miss, int_multi, int_prot, int_prefetch, int_timeout}), 64'd0);
        @(negedge clk);
        chk("rst_post_accept", 64'(accept), 64'b0001);
        chk("rst_post_drop", 64'(drop), 64'd0);
        chk("rst_post_busy", 64'(busy), 64'd1);
        sent = 4'b0001;
        @(negedge clk);
        chk("rst_post_ready", 64'(busy), 64'd0);
        sent       = '0;
        addr_valid = '0;
        to_seen    = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (int_timeout) to_seen++;
        end
        chk("rst_no_stale_timeout", 64'(to_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rab_arb_fsm.md
RAB_ARB_FSM -- requirements
Module: rab_arb_fsm

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 40, translated-address width.
REQ-002 SHALL have parameter NUM_PORTS, default 4, range 2..16, number of requesting slave ports.
REQ-003 SHALL have parameter TIMEOUT, default 255, range >=1, max WAIT cycles before forced return to READY.
REQ-004 Clk_CI  input  1  clock, all state on rising edge.
REQ-005 Rst_RBI  input  1  reset, asynchronous, active-low.
REQ-006 addr_valid  input  NUM_PORTS  per-port request valid.
REQ-007 sent  input  NUM_PORTS  per-port "transaction forwarded" pulse.
REQ-008 no_hit, multiple_hit, no_prot, prefetch, cache_coherent  input  1 each  lookup results for the granted port, same cycle as grant.
REQ-009 out_addr  input  AXI_ADDR_WIDTH  translated address for the granted port.
REQ-010 gnt_idx  output  clog2(NUM_PORTS)  combinational index of port selected for lookup (drives lookup input mux).
REQ-011 accept, drop, miss  output  NUM_PORTS each  registered one-hot per-port result pulses.
REQ-012 out_addr_reg  output  AXI_ADDR_WIDTH; cache_coherent_reg  output  1  registered lookup results.
REQ-013 int_miss, int_multi, int_prot, int_prefetch, int_timeout  output  1 each  registered interrupt pulses.
REQ-014 busy  output  1  high while state is WAIT.

Function
REQ-015 FSM SHALL have states READY and WAIT only.
REQ-016 gnt_idx SHALL be the first index i with addr_valid[i]=1 searching rr_ptr, rr_ptr+1, ... mod NUM_PORTS; gnt_idx = rr_ptr when no request.
REQ-017 A grant SHALL occur only in READY with |addr_valid=1; at most one grant per cycle.
REQ-018 On grant, next state SHALL be WAIT, gnt_reg <= gnt_idx, rr_ptr <= (gnt_idx+1) mod NUM_PORTS (wrap NUM_PORTS-1 -> 0).
REQ-019 Let err = no_hit | multiple_hit | ~no_prot | prefetch; on grant, accept[gnt_idx] <= ~err, drop[gnt_idx] <= err, miss[gnt_idx] <= no_hit, all other bits 0.
REQ-020 On grant: int_miss <= no_hit; int_multi <= multiple_hit; int_prot <= ~no_prot; int_prefetch <= ~no_hit & prefetch.
REQ-021 On grant out_addr_reg <= out_addr, cache_coherent_reg <= cache_coherent; otherwise both hold.
REQ-022 All accept/drop/miss/int_* outputs SHALL be one-cycle pulses, 0 in any cycle not following a grant (or timeout for int_timeout).
REQ-023 Result latency: outputs valid exactly 1 cycle after grant cycle, i.e. first WAIT cycle.
REQ-024 In WAIT, only sent[gnt_reg] SHALL return FSM to READY; sent on other ports ignored.
REQ-025 WAIT counter SHALL clear on entry, increment each WAIT cycle, and on reaching TIMEOUT without sent[gnt_reg] force READY and pulse int_timeout next cycle.
REQ-026 sent[gnt_reg] in the same cycle as counter reaching TIMEOUT: return to READY, no int_timeout.
REQ-027 sent in READY SHALL be ignored; addr_valid in WAIT SHALL not grant and not move rr_ptr.
REQ-028 After leaving WAIT, READY SHALL last at least one cycle before next grant (no back-to-back grant).

Reset
REQ-029 Rst_RBI low SHALL immediately force state READY, rr_ptr 0, gnt_reg 0, WAIT counter 0, all outputs 0, out_addr_reg '0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the transaction with no int_timeout and no result pulses after release.

Verification
REQ-031 NUM_PORTS=4, addr_valid=4'b1111 held, sent[gnt_reg] 2 cycles after each grant -> grants 0,1,2,3,0 in order.
REQ-032 rr_ptr=3, addr_valid=4'b1001, hit, no_prot=1 -> gnt_idx=3, next cycle accept=4'b1000, drop=0, rr_ptr=0.
REQ-033 Grant port 1 with no_hit=1 -> next cycle drop=4'b0010, miss=4'b0010, int_miss=1, accept=0, int_prefetch=0.
REQ-034 TIMEOUT=8, grant then no sent -> READY after 8 WAIT cycles, int_timeout 1-cycle pulse; sent[other port] meanwhile has no effect.
REQ-035 Multiple_hit=1 and no_prot=0 together on grant -> drop pulse, int_multi=1 and int_prot=1 same cycle.
REQ-036 Rst_RBI low during WAIT with addr_valid held -> after release grant to port 0, no stale pulses.
